// File: rtl/mac_controller.sv
// mac_controller: sequences one mac instance through a dot product of len
// operand pairs. Operands stream in on a valid/ready handshake and go to the
// MAC combinationally. The MAC sum is captured on the final pair and held
// on a result valid/ready handshake until the consumer takes it.
module mac_controller #(
  parameter int A_WIDTH      = 16,
  parameter int B_WIDTH      = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           arst_in,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [LEN_WIDTH-1:0]           len,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic signed [A_WIDTH-1:0]      op_a,
  input  logic signed [B_WIDTH-1:0]      op_b,
  output logic                           mac_input_valid,
  output logic                           mac_accumulate,
  output logic [A_WIDTH-1:0]             mac_a,
  output logic [B_WIDTH-1:0]             mac_b,
  input  logic signed [OUTPUT_WIDTH-1:0] mac_out,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic signed [OUTPUT_WIDTH-1:0] result,
  output logic                           busy
);

  // state | meaning
  // IDLE  | waiting for a command; start_ready high
  // RUN   | accepting operand pairs and driving the MAC
  // DONE  | result held until result_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 first;
  logic                 fire;

  // Handshake flags decode straight from the state register, so they are
  // glitch-free and carry no logic from the inputs.
  assign start_ready  = (state == IDLE);
  assign op_ready     = (state == RUN);
  assign result_valid = (state == DONE);
  assign busy         = (state == RUN) || (state == DONE);

  // MAC drive is combinational so a pair reaches the MAC in its fire cycle.
  // The first product of a command clears the accumulator by not accumulating.
  assign fire            = op_valid && op_ready;
  assign mac_input_valid = fire;
  assign mac_accumulate  = fire && !first;
  assign mac_a           = op_a;
  assign mac_b           = op_b;

  // Command/operand sequencing FSM with the captured result.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            remaining <= len;
            first     <= 1'b1;
            if (len == '0) begin
              result <= '0;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (fire) begin
            first     <= 1'b0;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              result <= mac_out;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_controller.sv
// tb_mac_controller: directed test of mac_controller driving a small
// behavioural mac (wrapping 16-bit product plus optional accumulator).
module tb_mac_controller;

  logic               clk;
  logic               arst_in;
  logic               start_valid;
  logic               start_ready;
  logic [7:0]         len;
  logic               op_valid;
  logic               op_ready;
  logic signed [15:0] op_a;
  logic signed [15:0] op_b;
  logic               mac_input_valid;
  logic               mac_accumulate;
  logic [15:0]        mac_a;
  logic [15:0]        mac_b;
  logic signed [15:0] mac_out;
  logic               result_valid;
  logic               result_ready;
  logic signed [15:0] result;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] va [256];
  logic signed [15:0] vb [256];

  mac_controller #(
    .A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(16), .LEN_WIDTH(8)
  ) dut (
    .clk(clk), .arst_in(arst_in),
    .start_valid(start_valid), .start_ready(start_ready), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_input_valid(mac_input_valid), .mac_accumulate(mac_accumulate),
    .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .busy(busy)
  );

  // Behavioural mac: out = a*b (+ acc when accumulating), wrapped to 16 bits
  logic [15:0] prod;
  logic [15:0] acc;
  assign prod    = mac_a * mac_b;
  assign mac_out = mac_accumulate ? signed'(acc + prod) : signed'(prod);

  always @(posedge clk or posedge arst_in) begin
    if (arst_in) acc <= '0;
    else if (mac_input_valid) acc <= mac_out;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_ready"}, start_ready, 16'd1);
    chk({tag, "_op_ready"}, op_ready, 16'd0);
    chk({tag, "_mac_iv"}, mac_input_valid, 16'd0);
    chk({tag, "_mac_acc"}, mac_accumulate, 16'd0);
    chk({tag, "_result_valid"}, result_valid, 16'd0);
    chk({tag, "_result"}, result, 16'd0);
    chk({tag, "_busy"}, busy, 16'd0);
  endtask

  // Accept a command and stream n pairs from va/vb back-to-back.
  task automatic do_cmd(input int n, input logic [15:0] exp_res, input string tag);
    start_valid = 1'b1;
    len         = 8'(n);
    #1;
    chk({tag, "_start_ready"}, start_ready, 16'd1);
    cyc();
    start_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      op_a     = va[i];
      op_b     = vb[i];
      op_valid = 1'b1;
      #1;
      chk({tag, "_iv"}, mac_input_valid, 16'd1);
      chk({tag, "_acc"}, mac_accumulate, (i == 0) ? 16'd0 : 16'd1);
      cyc();
    end
    op_valid = 1'b0;
    #1;
    chk({tag, "_result_valid"}, result_valid, 16'd1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_busy"}, busy, 16'd1);
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    #1;
    chk({tag, "_hs_start_ready"}, start_ready, 16'd1);
    chk({tag, "_hs_result_valid"}, result_valid, 16'd0);
  endtask

  initial begin
    arst_in      = 1'b1;
    start_valid  = 1'b0;
    len          = '0;
    op_valid     = 1'b0;
    op_a         = '0;
    op_b         = '0;
    result_ready = 1'b0;
    #12;
    chk_reset_vals("reset");
    arst_in = 1'b0;
    cyc();

    // len=3: (2,3),(4,5),(-1,6) -> 6+20-6 = 20; IDLE ignores op_valid
    start_valid = 1'b1; len = 8'd3;
    op_valid = 1'b1; op_a = 16'sd2; op_b = 16'sd3;
    #1;
    chk("t1_idle_iv", mac_input_valid, 16'd0);
    chk("t1_idle_op_ready", op_ready, 16'd0);
    cyc();
    start_valid = 1'b0;
    chk("t1_op_ready", op_ready, 16'd1);
    chk("t1_acc0", mac_accumulate, 16'd0);
    chk("t1_out0", mac_out, 16'd6);
    cyc();
    op_a = 16'sd4; op_b = 16'sd5; #1;
    chk("t1_acc1", mac_accumulate, 16'd1);
    cyc();
    op_a = -16'sd1; op_b = 16'sd6; #1;
    chk("t1_acc2", mac_accumulate, 16'd1);
    cyc();
    op_valid = 1'b0; #1;
    chk("t1_result_valid", result_valid, 16'd1);
    chk("t1_result", result, 16'd20);
    chk("t1_start_ready_done", start_ready, 16'd0);
    handshake("t1");

    // Two back-to-back len=2 commands; second is pending during the handshake
    va[0] = 16'sd1; vb[0] = 16'sd1; va[1] = 16'sd1; vb[1] = 16'sd1;
    do_cmd(2, 16'd2, "t2a");
    start_valid = 1'b1; len = 8'd2; result_ready = 1'b1;
    cyc();
    result_ready = 1'b0; #1;
    chk("t2_pending_start_ready", start_ready, 16'd1);
    chk("t2_pending_busy", busy, 16'd0);
    va[0] = 16'sd3; vb[0] = 16'sd3; va[1] = 16'sd1; vb[1] = 16'sd2;
    do_cmd(2, 16'd11, "t2b");
    handshake("t2b");

    // len=4 with a 3-cycle operand gap after pair 2; all (2,2) -> 16
    start_valid = 1'b1; len = 8'd4;
    cyc();
    start_valid = 1'b0;
    op_a = 16'sd2; op_b = 16'sd2;
    op_valid = 1'b1; cyc();
    op_valid = 1'b1; cyc();
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_gap_iv", mac_input_valid, 16'd0);
      chk("t3_gap_op_ready", op_ready, 16'd1);
      chk("t3_gap_result_valid", result_valid, 16'd0);
      cyc();
    end
    op_valid = 1'b1; #1;
    chk("t3_acc3", mac_accumulate, 16'd1);
    cyc();
    cyc();
    op_valid = 1'b0; #1;
    chk("t3_result_valid", result_valid, 16'd1);
    chk("t3_result", result, 16'd16);
    handshake("t3");

    // len=0: immediate zero result, no operand taken, result held 5 cycles
    start_valid = 1'b1; len = 8'd0;
    op_valid = 1'b1; op_a = 16'sd9; op_b = 16'sd9;
    cyc();
    #1;
    chk("t4_result_valid", result_valid, 16'd1);
    chk("t4_result", result, 16'd0);
    chk("t4_op_ready", op_ready, 16'd0);
    chk("t4_iv", mac_input_valid, 16'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_hold_result", result, 16'd0);
      chk("t4_hold_valid", result_valid, 16'd1);
      chk("t4_hold_start_ready", start_ready, 16'd0);
      chk("t4_hold_op_ready", op_ready, 16'd0);
    end
    start_valid = 1'b0; op_valid = 1'b0;
    handshake("t4");

    // Reset after 2 of 5 pairs, then len=1 (7,3) -> 21
    start_valid = 1'b1; len = 8'd5;
    cyc();
    start_valid = 1'b0;
    op_valid = 1'b1; op_a = 16'sd5; op_b = 16'sd5;
    cyc();
    cyc();
    #1;
    arst_in = 1'b1;
    #1;
    chk_reset_vals("t5_async");
    #1;
    arst_in = 1'b0;
    op_valid = 1'b0;
    cyc();
    chk_reset_vals("t5_after");
    va[0] = 16'sd7; vb[0] = 16'sd3;
    do_cmd(1, 16'd21, "t5");
    handshake("t5");

    // len=255 of (1,1) -> 255, then (32767,2) wraps to -2
    for (int i = 0; i < 255; i++) begin
      va[i] = 16'sd1; vb[i] = 16'sd1;
    end
    do_cmd(255, 16'd255, "t6a");
    handshake("t6a");
    va[0] = 16'sd32767; vb[0] = 16'sd2;
    do_cmd(1, 16'hFFFE, "t6b");
    handshake("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
